// File: rtl/id_ex_stage_if.sv
// ============================================================================
//  Module      : id_ex_stage_if
//  Description : ID -> EX bundle. The ID side drives the decoded instruction
//                and receives the stall. The EX side returns the registered
//                copy and the bubble/stall counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush_i;
  logic [2:0]       control_EX_i;
  logic [1:0]       control_MEM_i;
  logic [1:0]       control_WB_i;
  logic [XLEN-1:0]  rs1_data_i;
  logic [XLEN-1:0]  rs2_data_i;
  logic [XLEN-1:0]  imm_i;
  logic [9:0]       funct_i;
  logic [4:0]       rs1_addr_i;
  logic [4:0]       rs2_addr_i;
  logic [4:0]       rd_addr_i;

  logic             stall_o;
  logic [2:0]       control_EX_o;
  logic [1:0]       control_MEM_o;
  logic [1:0]       control_WB_o;
  logic [XLEN-1:0]  rs1_data_o;
  logic [XLEN-1:0]  rs2_data_o;
  logic [XLEN-1:0]  imm_o;
  logic [9:0]       funct_o;
  logic [4:0]       rs1_addr_o;
  logic [4:0]       rs2_addr_o;
  logic [4:0]       rd_addr_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output flush_i, control_EX_i, control_MEM_i, control_WB_i,
           rs1_data_i, rs2_data_i, imm_i, funct_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i,
    input  stall_o, control_EX_o, control_MEM_o, control_WB_o,
           rs1_data_o, rs2_data_o, imm_o, funct_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, bubble_cnt_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, control_EX_i, control_MEM_i, control_WB_i,
           rs1_data_i, rs2_data_i, imm_i, funct_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i,
    output stall_o, control_EX_o, control_MEM_o, control_WB_o,
           rs1_data_o, rs2_data_o, imm_o, funct_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, bubble_cnt_o, stall_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use hazard detection,
//                branch-flush bubbles and saturating bubble/stall counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  wire logic    clock_i,
  input  wire logic    rst_n_i,
  id_ex_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       control_ex_q,  control_ex_d;
  logic [1:0]       control_mem_q, control_mem_d;
  logic [1:0]       control_wb_q,  control_wb_d;
  logic [XLEN-1:0]  rs1_data_q,    rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q,    rs2_data_d;
  logic [XLEN-1:0]  imm_q,         imm_d;
  logic [9:0]       funct_q,       funct_d;
  logic [4:0]       rs1_addr_q,    rs1_addr_d;
  logic [4:0]       rs2_addr_q,    rs2_addr_d;
  logic [4:0]       rd_addr_q,     rd_addr_d;
  logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

  logic hazard;
  logic bubble;
  logic stall;

  // A load in EX whose destination feeds either ID source must wait one cycle.
  always_comb begin
    hazard = control_mem_q[1] && (rd_addr_q != 5'd0) &&
             ((rd_addr_q == bus.rs1_addr_i) || (rd_addr_q == bus.rs2_addr_i));
    // A flushed ID instruction is discarded, so there is nothing to hold.
    stall  = hazard && !bus.flush_i && rst_n_i;
    bubble = hazard || bus.flush_i;
  end

  always_comb begin
    control_ex_d  = bubble ? 3'b000 : bus.control_EX_i;
    control_mem_d = bubble ? 2'b00  : bus.control_MEM_i;
    control_wb_d  = bubble ? 2'b00  : bus.control_WB_i;
    rs1_data_d    = bus.rs1_data_i;
    rs2_data_d    = bus.rs2_data_i;
    imm_d         = bus.imm_i;
    funct_d       = bus.funct_i;
    rs1_addr_d    = bus.rs1_addr_i;
    rs2_addr_d    = bus.rs2_addr_i;
    rd_addr_d     = bus.rd_addr_i;

    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!rst_n_i) begin
      control_ex_q  <= '0;
      control_mem_q <= '0;
      control_wb_q  <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      funct_q       <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_addr_q     <= '0;
      bubble_cnt_q  <= '0;
      stall_cnt_q   <= '0;
    end else begin
      control_ex_q  <= control_ex_d;
      control_mem_q <= control_mem_d;
      control_wb_q  <= control_wb_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      imm_q         <= imm_d;
      funct_q       <= funct_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_addr_q     <= rd_addr_d;
      bubble_cnt_q  <= bubble_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.stall_o       = stall;
  assign bus.control_EX_o  = control_ex_q;
  assign bus.control_MEM_o = control_mem_q;
  assign bus.control_WB_o  = control_wb_q;
  assign bus.rs1_data_o    = rs1_data_q;
  assign bus.rs2_data_o    = rs2_data_q;
  assign bus.imm_o         = imm_q;
  assign bus.funct_o       = funct_q;
  assign bus.rs1_addr_o    = rs1_addr_q;
  assign bus.rs2_addr_o    = rs2_addr_q;
  assign bus.rd_addr_o     = rd_addr_q;
  assign bus.bubble_cnt_o  = bubble_cnt_q;
  assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

`default_nettype wire
